// File: rtl/fifo_ddr_wr_burst_if.sv
// Bus bundle between the burst writer, the FIFO read port and the DDR AXI write port.
// master: the burst writer (drives fifo_rd_en and the AW/W channels, bready).
// slave : the FIFO read side plus the DDR AXI slave.
interface fifo_ddr_wr_burst_if #(
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned LEVEL_WIDTH = 13
);
  logic                   fifo_rd_en;
  logic [31:0]            fifo_rd_data;
  logic                   fifo_rd_empty;
  logic [LEVEL_WIDTH-1:0] fifo_rd_level;
  logic [ADDR_WIDTH-1:0]  m_awaddr;
  logic [7:0]             m_awlen;
  logic                   m_awvalid;
  logic                   m_awready;
  logic [31:0]            m_wdata;
  logic                   m_wvalid;
  logic                   m_wready;
  logic                   m_wlast;
  logic                   m_bvalid;
  logic [1:0]             m_bresp;
  logic                   m_bready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_level,
    output m_awaddr, m_awlen, m_awvalid,
    input  m_awready,
    output m_wdata, m_wvalid, m_wlast,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_rd_empty, fifo_rd_level,
    input  m_awaddr, m_awlen, m_awvalid,
    output m_awready,
    input  m_wdata, m_wvalid, m_wlast,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready
  );
endinterface

// File: rtl/fifo_ddr_wr_burst.sv
// Drains the async FIFO read side into fixed-length AXI write bursts with frame-relative,
// wrapping DDR addresses.
// Ports: clk, rst_n (async, active low), frame_start (restart addressing at BASE_ADDR),
//        bus (fifo_ddr_wr_burst_if.master: FIFO read port + AXI AW/W/B), wr_err (sticky
//        non-OKAY response), busy (not idle).
// Optional: define FIFO_FLUSH_EN to add the level input 'flush', which lets a partial
//           FIFO content (1..BURST_LEN-1 words) go out as a short burst.
module fifo_ddr_wr_burst #(
  parameter int unsigned           BURST_LEN   = 16,
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           FRAME_WORDS = 1024 * 768,
  parameter int unsigned           LEVEL_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
`ifdef FIFO_FLUSH_EN
  input  logic                      flush,
`endif
  fifo_ddr_wr_burst_if.master       bus,
  output logic                      wr_err,
  output logic                      busy
);

  localparam int unsigned            CntW       = 9;
  localparam logic [CntW-1:0]        BurstBeats = CntW'(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] BurstLevel = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [7:0]             FullAwlen  = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0]    EndAddr    =
      {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(FRAME_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  awvalid_q, awvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic [CntW-1:0]       beats_q, beats_d;   // beats in the current burst
  logic [CntW-1:0]       req_q, req_d;       // FIFO reads issued this burst
  logic [CntW-1:0]       sent_q, sent_d;     // W beats accepted this burst
  logic                  inflight_q, inflight_d;
  logic [31:0]           buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  restart_q, restart_d;
  logic                  wr_err_q, wr_err_d;

  logic                  wvalid, wlast, pop, rd_en, burst_go;
  logic [1:0]            occ_after_pop;
  logic [2:0]            fill;
  logic [CntW-1:0]       go_beats;
  logic [ADDR_WIDTH:0]   next_addr;

  always_comb begin
    // W is only offered once AW has been accepted, keeping data behind its address.
    wvalid        = (state_q == StData) && (occ_q != 2'd0);
    wlast         = wvalid && (sent_q == beats_q - 9'd1);
    pop           = wvalid && bus.m_wready;
    occ_after_pop = occ_q - {1'b0, pop};
    // Occupancy is counted after this cycle's dequeue so a full-rate stream keeps one
    // word buffered and one read in flight.
    fill  = {1'b0, occ_after_pop} + {2'b00, inflight_q};
    rd_en = ((state_q == StAddr) || (state_q == StData)) && (req_q < beats_q) &&
            (fill < 3'd2) && !bus.fifo_rd_empty;

    // Skid buffer: head in buf0; shift on pop, then land the returning read word.
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) buf0_d = buf1_q;
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) buf0_d = bus.fifo_rd_data;
      else                       buf1_d = bus.fifo_rd_data;
    end
    occ_d      = fill[1:0] + {1'b0, rd_en & 1'b0};
    inflight_d = rd_en;

    go_beats = BurstBeats;
    burst_go = (bus.fifo_rd_level >= BurstLevel);
`ifdef FIFO_FLUSH_EN
    if (!burst_go && flush && (bus.fifo_rd_level != '0) && !bus.fifo_rd_empty) begin
      burst_go = 1'b1;
      go_beats = CntW'(bus.fifo_rd_level);
    end
`endif

    next_addr = {1'b0, awaddr_q} + (ADDR_WIDTH + 1)'({beats_q, 2'b00});

    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beats_d   = beats_q;
    req_d     = req_q + {8'd0, rd_en};
    sent_d    = sent_q + {8'd0, pop};
    restart_d = restart_q;
    wr_err_d  = wr_err_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) awaddr_d = BASE_ADDR;
        if (burst_go) begin
          state_d = StAddr;
          beats_d = go_beats;
          awlen_d = 8'(go_beats - 9'd1);
          req_d   = '0;
          sent_d  = '0;
        end
      end
      StAddr: begin
        if (frame_start) restart_d = 1'b1;
        if (bus.m_awready) state_d = StData;
      end
      StData: begin
        if (frame_start) restart_d = 1'b1;
        if (pop && wlast) state_d = StResp;
      end
      StResp: begin
        if (frame_start) restart_d = 1'b1;
        if (bus.m_bvalid) begin
          if (bus.m_bresp != 2'b00) wr_err_d = 1'b1;
          // A restart seen during the burst (or on this very cycle) beats the increment.
          if (restart_q || frame_start)  awaddr_d = BASE_ADDR;
          else if (next_addr == EndAddr) awaddr_d = BASE_ADDR;
          else                           awaddr_d = next_addr[ADDR_WIDTH-1:0];
          restart_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    awvalid_d = (state_d == StAddr);
    bready_d  = (state_d == StResp);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      awaddr_q   <= BASE_ADDR;
      awlen_q    <= FullAwlen;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      beats_q    <= BurstBeats;
      req_q      <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= '0;
      restart_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      bready_q   <= bready_d;
      busy_q     <= busy_d;
      beats_q    <= beats_d;
      req_q      <= req_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      restart_q  <= restart_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_awaddr   = awaddr_q;
  assign bus.m_awlen    = awlen_q;
  assign bus.m_awvalid  = awvalid_q;
  assign bus.m_wdata    = buf0_q;
  assign bus.m_wvalid   = wvalid;
  assign bus.m_wlast    = wlast;
  assign bus.m_bready   = bready_q;
  assign wr_err         = wr_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_fifo_ddr_wr_burst.sv
// Bench for fifo_ddr_wr_burst: queue-based FIFO model, randomized AXI slave, and a
// reference address/data model derived from the burst, wrap and restart rules.
module tb_fifo_ddr_wr_burst;
  localparam int unsigned BurstLen   = 16;
  localparam int unsigned AddrW      = 28;
  localparam int unsigned LevelW     = 13;
  localparam int unsigned FrameWords = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame_start = 1'b0;
  logic wr_err, busy;
`ifdef FIFO_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_ddr_wr_burst_if #(.ADDR_WIDTH(AddrW), .LEVEL_WIDTH(LevelW)) bus ();

  fifo_ddr_wr_burst #(
    .BURST_LEN  (BurstLen),
    .ADDR_WIDTH (AddrW),
    .BASE_ADDR  (28'h0),
    .FRAME_WORDS(FrameWords),
    .LEVEL_WIDTH(LevelW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
`ifdef FIFO_FLUSH_EN
    .flush      (flush),
`endif
    .bus        (bus.master),
    .wr_err     (wr_err),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // FIFO read-side model: data appears one cycle after rd_en, level/empty follow the queue.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_data[$];
  int avail_target = 0;
  int pushed = 0;
  int underflow = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      pushed = avail_target;
      bus.fifo_rd_data  <= '0;
      bus.fifo_rd_level <= '0;
      bus.fifo_rd_empty <= 1'b1;
    end else begin
      if (bus.fifo_rd_en) begin
        if (fifo_q.size() > 0) bus.fifo_rd_data <= fifo_q.pop_front();
        else underflow++;
      end
      while (pushed < avail_target) begin
        logic [31:0] w;
        w = {16'($urandom), 16'(pushed)};
        fifo_q.push_back(w);
        exp_data.push_back(w);
        pushed++;
      end
      bus.fifo_rd_level <= LevelW'(fifo_q.size());
      bus.fifo_rd_empty <= (fifo_q.size() == 0);
    end
  end

  // AXI slave: ready/valid either tied high or randomized per cycle.
  bit aw_rand = 0, w_rand = 0, b_rand = 0;
  int err_idx = -1;
  int b_cnt = 0;

  always @(posedge clk) begin
    #1;
    bus.m_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.m_wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.m_bvalid  = bus.m_bready && (!b_rand || ($urandom_range(0, 1) == 1));
    bus.m_bresp   = (b_cnt == err_idx) ? 2'b10 : 2'b00;
  end

  // Monitor on the falling edge: logs handshakes and checks AXI valid stability.
  logic [AddrW-1:0] aw_addr_log[$];
  logic [7:0]       aw_len_log[$];
  logic [31:0]      w_data_log[$];
  logic             w_last_log[$];
  int               w_cyc_log[$];
  int cyc = 0, rd_en_cnt = 0, awv_cnt = 0, viol = 0;
  logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_wl = 0;
  logic [AddrW-1:0] prev_addr = '0;
  logic [7:0]       prev_len = '0;
  logic [31:0]      prev_wd = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_awv = 0;
      prev_wv  = 0;
    end else begin
      if (bus.fifo_rd_en) rd_en_cnt++;
      if (bus.m_awvalid) awv_cnt++;
      if (prev_awv && !prev_awr && (!bus.m_awvalid || bus.m_awaddr !== prev_addr ||
          bus.m_awlen !== prev_len)) viol++;
      if (prev_wv && !prev_wr && (!bus.m_wvalid || bus.m_wdata !== prev_wd ||
          bus.m_wlast !== prev_wl)) viol++;
      if (bus.m_awvalid && bus.m_awready) begin
        aw_addr_log.push_back(bus.m_awaddr);
        aw_len_log.push_back(bus.m_awlen);
      end
      if (bus.m_wvalid && bus.m_wready) begin
        w_data_log.push_back(bus.m_wdata);
        w_last_log.push_back(bus.m_wlast);
        w_cyc_log.push_back(cyc);
      end
      if (bus.m_bvalid && bus.m_bready) b_cnt++;
      prev_awv  = bus.m_awvalid;
      prev_awr  = bus.m_awready;
      prev_addr = bus.m_awaddr;
      prev_len  = bus.m_awlen;
      prev_wv   = bus.m_wvalid;
      prev_wr   = bus.m_wready;
      prev_wd   = bus.m_wdata;
      prev_wl   = bus.m_wlast;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  int model_addr = 0;
  int aw_idx = 0;
  int w_idx = 0;

  task automatic expect_burst(input string tag, input int len, input bit restart);
    int n;
    int nxt;
    n = 0;
    while (b_cnt <= aw_idx && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(b_cnt > aw_idx), 64'd1);
    if (b_cnt > aw_idx) begin
      check({tag, "_addr"}, 64'(aw_addr_log[aw_idx]), 64'(model_addr));
      check({tag, "_len"}, 64'(aw_len_log[aw_idx]), 64'(len - 1));
      check({tag, "_beats"}, 64'(w_data_log.size() >= w_idx + len), 64'd1);
      if (w_data_log.size() >= w_idx + len && exp_data.size() >= w_idx + len) begin
        for (int i = 0; i < len; i++) begin
          check({tag, "_wdata"}, 64'(w_data_log[w_idx + i]), 64'(exp_data[w_idx + i]));
          check({tag, "_wlast"}, 64'(w_last_log[w_idx + i]), 64'(i == len - 1));
        end
      end
      w_idx += len;
      aw_idx++;
    end
    nxt = model_addr + len * 4;
    if (restart || nxt == int'(FrameWords * 4)) model_addr = 0;
    else model_addr = nxt;
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (w_data_log.size() < w_idx + k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_beats", 64'(w_data_log.size() >= w_idx + k), 64'd1);
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    int a0, r0, n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awaddr", 64'(bus.m_awaddr), 64'h0);
    check("rst_awlen", 64'(bus.m_awlen), 64'(BurstLen - 1));
    check("rst_awvalid", 64'(bus.m_awvalid), 64'd0);
    check("rst_wvalid", 64'(bus.m_wvalid), 64'd0);
    check("rst_wlast", 64'(bus.m_wlast), 64'd0);
    check("rst_bready", 64'(bus.m_bready), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_wr_err", 64'(wr_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // One full burst at full rate.
    r0 = rd_en_cnt;
    avail_target += 16;
    expect_burst("t1", 16, 0);
    check("t1_rd_en_cnt", 64'(rd_en_cnt - r0), 64'd16);
    if (w_cyc_log.size() >= 16)
      check("t1_back_to_back", 64'(w_cyc_log[15] - w_cyc_log[0]), 64'd15);

    // One word short of a burst: nothing may start.
    avail_target += 15;
    repeat (3) @(negedge clk);
    a0 = awv_cnt;
    r0 = rd_en_cnt;
    repeat (100) @(negedge clk);
    check("t2_no_awvalid", 64'(awv_cnt - a0), 64'd0);
    check("t2_no_rd_en", 64'(rd_en_cnt - r0), 64'd0);
    check("t2_idle", 64'(busy), 64'd0);
    avail_target += 1;
    n = 0;
    while (!bus.m_awvalid && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("t2_start_latency", 64'(bus.m_awvalid && n <= 2), 64'd1);
    expect_burst("t2", 16, 0);

    // Randomized handshakes over four bursts; one error response.
    aw_rand = 1;
    w_rand  = 1;
    b_rand  = 1;
    err_idx = 3;
    avail_target += 64;
    expect_burst("t3a", 16, 0);
    @(negedge clk);
    check("t3_err_clear", 64'(wr_err), 64'd0);
    expect_burst("t3b", 16, 0);
    @(negedge clk);
    check("t3_err_set", 64'(wr_err), 64'd1);
    expect_burst("t3c", 16, 0);
    expect_burst("t3d", 16, 0);
    err_idx = -1;
    check("t3_stability", 64'(viol), 64'd0);

    // frame_start twice during DATA collapses into one restart.
    avail_target += 16;
    wait_beats(5);
    pulse_frame_start();
    @(negedge clk);
    pulse_frame_start();
    expect_burst("t4a", 16, 1);
    avail_target += 16;
    expect_burst("t4b", 16, 0);
    @(negedge clk);
    check("t4_err_sticky", 64'(wr_err), 64'd1);

    // frame_start while idle takes effect at once.
    repeat (5) @(negedge clk);
    check("t5_idle", 64'(busy), 64'd0);
    pulse_frame_start();
    model_addr = 0;
    avail_target += 16;
    expect_burst("t5", 16, 0);

`ifdef FIFO_FLUSH_EN
    repeat (3) @(negedge clk);
    flush = 1'b1;
    avail_target += 5;
    expect_burst("t6a", 5, 0);
    flush = 1'b0;
    avail_target += 16;
    expect_burst("t6b", 16, 0);
`endif

    repeat (3) @(negedge clk);
    check("rd_en_total", 64'(rd_en_cnt), 64'(w_idx));
    check("no_underflow", 64'(underflow), 64'd0);
    check("stability_all", 64'(viol), 64'd0);

    // Reset in the middle of a burst.
    avail_target += 16;
    wait_beats(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_awaddr", 64'(bus.m_awaddr), 64'h0);
    check("mid_rst_awlen", 64'(bus.m_awlen), 64'(BurstLen - 1));
    check("mid_rst_awvalid", 64'(bus.m_awvalid), 64'd0);
    check("mid_rst_wvalid", 64'(bus.m_wvalid), 64'd0);
    check("mid_rst_wlast", 64'(bus.m_wlast), 64'd0);
    check("mid_rst_bready", 64'(bus.m_bready), 64'd0);
    check("mid_rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("mid_rst_wr_err", 64'(wr_err), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ddr_wr_burst.md
Name: fifo_ddr_wr_burst

Overview:
- Drains the read side of the 1024x32b async FIFO in the DDR clock domain.
- Packs the stored words into fixed-length AXI3/AXI4-style write bursts for the DDR controller's write port.
- Generates frame-relative DDR addresses, with wrap at the end of the frame buffer.
- Sits directly downstream of the FIFO, on the FIFO's rd_clk, and upstream of the DDR AXI slave.

Parameters:
- BURST_LEN, 16, beats per burst (2..256); awlen = BURST_LEN-1.
- ADDR_WIDTH, 28, AXI byte-address width.
- BASE_ADDR, 0, byte address of the first word of the frame buffer; multiple of BURST_LEN*4.
- FRAME_WORDS, 1024*768, 32-bit words per frame; multiple of BURST_LEN.
- LEVEL_WIDTH, 13, width of the FIFO read water level.

Ports:
- clk, input, 1, DDR user clock; same clock as the FIFO rd_clk.
- rst_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, single-cycle pulse; restarts addressing at BASE_ADDR.
- fifo_rd_en, output, 1, FIFO read enable.
- fifo_rd_data, input, 32, FIFO read data; valid one cycle after fifo_rd_en (no output register).
- fifo_rd_empty, input, 1, FIFO empty.
- fifo_rd_level, input, LEVEL_WIDTH, FIFO read water level.
- m_awaddr, output, ADDR_WIDTH, burst start byte address.
- m_awlen, output, 8, burst length minus 1.
- m_awvalid, output, 1, address valid.
- m_awready, input, 1, address ready.
- m_wdata, output, 32, write data.
- m_wvalid, output, 1, write data valid.
- m_wready, input, 1, write data ready.
- m_wlast, output, 1, last beat of the burst.
- m_bvalid, input, 1, write response valid.
- m_bresp, input, 2, write response code.
- m_bready, output, 1, response ready.
- wr_err, output, 1, sticky flag; set on any non-OKAY bresp.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; m_awaddr = BASE_ADDR; m_awlen = BURST_LEN-1; FSM in IDLE; beat counter 0; skid buffer empty.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE -> ADDR when fifo_rd_level >= BURST_LEN. m_awvalid rises on the cycle after the decision.
- ADDR: hold m_awvalid and m_awaddr stable until m_awready. On the handshake cycle go to DATA.
- DATA: stream exactly BURST_LEN beats. m_wlast is high only on beat BURST_LEN-1. After the wvalid&&wready handshake with wlast, go to RESP.
- RESP: m_bready = 1. On m_bvalid:
  - if m_bresp != 0, set wr_err;
  - advance the address by BURST_LEN*4;
  - return to IDLE.
- Data path uses a 2-entry skid buffer so the FIFO's 1-cycle read latency never stalls W.
- fifo_rd_en = 1 only when all hold:
  - state is ADDR or DATA;
  - words requested this burst < BURST_LEN;
  - buffer occupancy + in-flight reads < 2;
  - !fifo_rd_empty.
- Sustained throughput is 1 beat/cycle while m_wready = 1.
- No more than BURST_LEN reads are issued per burst; the level check guarantees availability.
- m_wvalid = buffer non-empty. m_wvalid does not drop while waiting for m_wready (AXI stability).
- Address wrap: if next address == BASE_ADDR + FRAME_WORDS*4, next address = BASE_ADDR.
- frame_start:
  - in IDLE, takes effect immediately and the next burst starts at BASE_ADDR;
  - in any other state, latched and applied at the RESP -> IDLE transition, overriding the increment;
  - multiple pulses during one burst collapse into one.
- Simultaneous IDLE level-trigger and frame_start: the new burst uses BASE_ADDR.
- Reset asserted mid-burst aborts immediately with all outputs at reset values. The DDR side and FIFO are reset together by system design.
- wr_err clears only on rst_n.

Optional Feature:
- Macro FIFO_FLUSH_EN. When defined, adds input port flush (1 bit, level).
- With flush:
  - in IDLE with flush = 1, fifo_rd_level in 1..BURST_LEN-1 and FIFO not empty, issue a short burst with m_awlen = level-1;
  - that level is sampled at the IDLE decision and used as the beat count;
  - after RESP the address advances by level*4 (wrap rule unchanged).
- Without the macro: no flush port; only full bursts are issued; residual words wait for more data.

Test Plan:
- Reset, FIFO preloaded with 16 words 0..15, awready and wready tied 1 -> one burst: awaddr = 0, awlen = 15; wdata 0..15 on 16 consecutive cycles; wlast on the 16th beat; fifo_rd_en high for exactly 16 cycles.
- Level 15 held 100 cycles -> awvalid never rises, fifo_rd_en stays 0. Level -> 16 -> burst starts within 2 cycles.
- wready random 50% over 4 bursts (64 words) -> wdata sequence intact, no duplicates or drops, wvalid held while wready = 0. Addresses 0x0, 0x40, 0x80, 0xC0.
- FRAME_WORDS = 32, 3 bursts -> addresses 0x0, 0x40, 0x0. frame_start pulsed mid-DATA of burst 1 -> burst 2 at 0x0, a single restart.
- bresp = 2'b10 on burst 2 -> wr_err = 1 and stays 1 through later OKAY bursts until rst_n is low.
- FIFO_FLUSH_EN defined, level 5, flush = 1 -> awlen = 4, 5 beats, wlast on beat 5, next awaddr = previous + 0x14.
